// File: rtl/poci_arbiter_2x1.sv
// Two-master to one-slave POCI arbiter with round-robin grant,
// registered response and optional ACCESS-phase timeout.
module poci_arbiter_2x1 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic              m0_pwrite,
    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic              m1_pwrite,
    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic [ADDR_W-1:0] s_paddr,
    output logic              s_pwrite,
    output logic              s_psel,
    output logic              s_penable,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic [DATA_W-1:0] s_prdata,
    input  logic              s_pready,
    input  logic              s_pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [15:0] TO_LAST =
        (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic              owner;
    logic              last_grant;
    logic              pick;
    logic              take;
    logic              done;
    logic              tmo;
    logic [15:0]       wait_cnt;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    // Master penable carries no information the arbiter needs.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    always_comb begin
        state_nx  = state;
        pick      = 1'b0;
        take      = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_psel || m1_psel) begin
                    take     = 1'b1;
                    pick     = (m0_psel && m1_psel) ? ~last_grant : m1_psel;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                s_psel   = 1'b1;
                state_nx = ACCESS;
            end
            ACCESS: begin
                s_psel    = 1'b1;
                s_penable = 1'b1;
                // A ready on the last allowed cycle still wins over timeout.
                if (s_pready) begin
                    done     = 1'b1;
                    state_nx = RESP;
                end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                    tmo      = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            s_paddr    <= '0;
            s_pwrite   <= 1'b0;
            s_pwdata   <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                owner    <= pick;
                s_paddr  <= pick ? m1_paddr : m0_paddr;
                s_pwrite <= pick ? m1_pwrite : m0_pwrite;
                s_pwdata <= pick ? m1_pwdata : m0_pwdata;
            end
            if (done) begin
                resp_data <= s_prdata;
                resp_err  <= s_pslverr;
            end
            if (tmo) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
            end
            if (state == RESP) begin
                last_grant <= owner;
            end
            if (state == ACCESS) begin
                wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign m0_pready  = (state == RESP) && !owner;
    assign m1_pready  = (state == RESP) && owner;
    assign m0_prdata  = resp_data;
    assign m1_prdata  = resp_data;
    assign m0_pslverr = resp_err;
    assign m1_pslverr = resp_err;

endmodule

// File: tb/tb_poci_arbiter_2x1.sv
// Bench for poci_arbiter_2x1: transaction-level model of grant order,
// phase timing and response, driven by directed and random traffic.
module tb_poci_arbiter_2x1;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] m_paddr   [2];
    logic          m_pwrite  [2];
    logic          m_psel    [2];
    logic          m_penable [2];
    logic [DW-1:0] m_pwdata  [2];
    logic [DW-1:0] m_prdata  [2];
    logic          m_pready  [2];
    logic          m_pslverr [2];
    logic [AW-1:0] s_paddr;
    logic          s_pwrite;
    logic          s_psel;
    logic          s_penable;
    logic [DW-1:0] s_pwdata;
    logic [DW-1:0] s_prdata;
    logic          s_pready;
    logic          s_pslverr;

    poci_arbiter_2x1 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_paddr   (m_paddr[0]),
        .m0_pwrite  (m_pwrite[0]),
        .m0_psel    (m_psel[0]),
        .m0_penable (m_penable[0]),
        .m0_pwdata  (m_pwdata[0]),
        .m0_prdata  (m_prdata[0]),
        .m0_pready  (m_pready[0]),
        .m0_pslverr (m_pslverr[0]),
        .m1_paddr   (m_paddr[1]),
        .m1_pwrite  (m_pwrite[1]),
        .m1_psel    (m_psel[1]),
        .m1_penable (m_penable[1]),
        .m1_pwdata  (m_pwdata[1]),
        .m1_prdata  (m_prdata[1]),
        .m1_pready  (m_pready[1]),
        .m1_pslverr (m_pslverr[1]),
        .s_paddr    (s_paddr),
        .s_pwrite   (s_pwrite),
        .s_psel     (s_psel),
        .s_penable  (s_penable),
        .s_pwdata   (s_pwdata),
        .s_prdata   (s_prdata),
        .s_pready   (s_pready),
        .s_pslverr  (s_pslverr)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // stimulus controls
    bit          rst_req;
    int          prob [2];
    bit          fix_en [2];
    logic [31:0] fix_addr [2];
    logic [31:0] fix_data [2];
    bit          fix_wr [2];
    int          force_w;
    int          force_err;
    bit          force_rd_en;
    logic [31:0] force_rd;

    // master request state
    bit          pend [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_data [2];
    bit          r_wr [2];

    // transaction model: t counts cycles since grant, a is ACCESS length
    bit          rst_q;
    bit          busy;
    bit          owner;
    bit          last;
    int          t;
    int          a;
    int          w;
    bit          tmo;
    logic [31:0] g_addr;
    logic [31:0] g_data;
    bit          g_wr;
    logic [31:0] rd;
    bit          er;
    int          done_q [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_q) begin
            busy = 1'b0;
            last = 1'b1;
        end else if (busy) begin
            t++;
            if (t == a + 3) busy = 1'b0;
        end

        if (busy && t >= 1 && t <= a + 1) begin
            chk("s_psel_xfer", s_psel, 1);
            chk("s_penable_xfer", s_penable, (t >= 2) ? 1 : 0);
            chk("s_paddr", s_paddr, g_addr);
            chk("s_pwdata", s_pwdata, g_data);
            chk("s_pwrite", s_pwrite, g_wr);
            chk("m0_pready_busy", m_pready[0], 0);
            chk("m1_pready_busy", m_pready[1], 0);
        end else if (busy && t == a + 2) begin
            chk("s_psel_resp", s_psel, 0);
            chk("s_penable_resp", s_penable, 0);
            chk("owner_pready", m_pready[owner], 1);
            chk("other_pready", m_pready[!owner], 0);
            chk("owner_prdata", m_prdata[owner], tmo ? 32'h0 : rd);
            chk("owner_pslverr", m_pslverr[owner], tmo ? 1 : er);
        end else begin
            chk("s_psel_idle", s_psel, 0);
            chk("s_penable_idle", s_penable, 0);
            chk("m0_pready_idle", m_pready[0], 0);
            chk("m1_pready_idle", m_pready[1], 0);
        end
        if (rst_q) begin
            chk("rst_prdata", m_prdata[0], 0);
            chk("rst_pslverr", m_pslverr[0], 0);
        end

        for (int x = 0; x < 2; x++) begin
            if (m_pready[x] === 1'b1) done_q.push_back(x);
        end

        if (busy && t == a + 2) begin
            pend[owner] = 1'b0;
            last        = owner;
        end

        for (int x = 0; x < 2; x++) begin
            if (!pend[x] && $urandom_range(99) < prob[x]) begin
                pend[x]   = 1'b1;
                r_addr[x] = fix_en[x] ? fix_addr[x] : $urandom;
                r_data[x] = fix_en[x] ? fix_data[x] : $urandom;
                r_wr[x]   = fix_en[x] ? fix_wr[x] : 1'($urandom_range(1));
            end
            m_psel[x]    = pend[x];
            m_penable[x] = pend[x];
            m_paddr[x]   = r_addr[x];
            m_pwdata[x]  = r_data[x];
            m_pwrite[x]  = r_wr[x];
        end

        reset = rst_req;
        rst_q = rst_req;

        if (!busy && !rst_req && (pend[0] || pend[1])) begin
            owner  = (pend[0] && pend[1]) ? !last : pend[1];
            busy   = 1'b1;
            t      = 0;
            g_addr = r_addr[owner];
            g_data = r_data[owner];
            g_wr   = r_wr[owner];
            w      = (force_w >= 0) ? force_w : int'($urandom_range(6));
            tmo    = (w >= TO);
            a      = tmo ? TO : w + 1;
            rd     = force_rd_en ? force_rd : $urandom;
            er     = (force_err >= 0) ? force_err[0]
                                      : ($urandom_range(3) == 0);
        end

        if (busy && t >= 2 && t - 2 == w) begin
            s_pready  = 1'b1;
            s_prdata  = rd;
            s_pslverr = er;
        end else if (busy && t >= 2 && t <= a + 1) begin
            s_pready  = 1'b0;
            s_prdata  = $urandom;
            s_pslverr = 1'($urandom_range(1));
        end else begin
            s_pready  = 1'($urandom_range(1));
            s_prdata  = $urandom;
            s_pslverr = 1'($urandom_range(1));
        end
    endtask

    initial begin
        int k;
        reset       = 1'b1;
        rst_req     = 1'b1;
        rst_q       = 1'b1;
        busy        = 1'b0;
        last        = 1'b1;
        force_w     = -1;
        force_err   = -1;
        force_rd_en = 1'b0;
        force_rd    = '0;
        s_prdata    = '0;
        s_pready    = 1'b0;
        s_pslverr   = 1'b0;
        for (int x = 0; x < 2; x++) begin
            prob[x]      = 0;
            fix_en[x]    = 1'b0;
            fix_addr[x]  = '0;
            fix_data[x]  = '0;
            fix_wr[x]    = 1'b0;
            pend[x]      = 1'b0;
            r_addr[x]    = '0;
            r_data[x]    = '0;
            r_wr[x]      = 1'b0;
            m_psel[x]    = 1'b0;
            m_penable[x] = 1'b0;
            m_paddr[x]   = '0;
            m_pwdata[x]  = '0;
            m_pwrite[x]  = 1'b0;
        end

        // reset state
        repeat (3) step();
        rst_req = 1'b0;
        step();

        // single write from m0
        done_q.delete();
        fix_en[0] = 1'b1;
        fix_addr[0] = 32'h10;
        fix_data[0] = 32'hA;
        fix_wr[0] = 1'b1;
        force_w = 0;
        prob[0] = 100;
        step();
        prob[0] = 0;
        repeat (6) step();
        chk("write_count", done_q.size(), 1);
        if (done_q.size() > 0) chk("write_owner", done_q[0], 0);

        // read with three wait states from m1
        done_q.delete();
        fix_en[1] = 1'b1;
        fix_addr[1] = 32'h20;
        fix_wr[1] = 1'b0;
        force_w = 3;
        force_err = 0;
        force_rd_en = 1'b1;
        force_rd = 32'h5;
        prob[1] = 100;
        step();
        prob[1] = 0;
        repeat (9) step();
        chk("read_count", done_q.size(), 1);
        if (done_q.size() > 0) chk("read_owner", done_q[0], 1);

        // timeout: slave never ready
        fix_en[0] = 1'b0;
        fix_en[1] = 1'b0;
        force_rd_en = 1'b0;
        force_err = -1;
        force_w = 6;
        prob[0] = 100;
        step();
        prob[0] = 0;
        repeat (9) step();

        // slave error
        force_w = 1;
        force_err = 1;
        prob[1] = 100;
        step();
        prob[1] = 0;
        repeat (7) step();
        force_err = -1;

        // contention right after reset
        rst_req = 1'b1;
        repeat (2) step();
        rst_req = 1'b0;
        done_q.delete();
        force_w = 0;
        prob[0] = 100;
        prob[1] = 100;
        repeat (16) step();
        chk("rr_count", (done_q.size() >= 4) ? 1 : 0, 1);
        if (done_q.size() >= 4) begin
            chk("rr_order0", done_q[0], 0);
            chk("rr_order1", done_q[1], 1);
            chk("rr_order2", done_q[2], 0);
            chk("rr_order3", done_q[3], 1);
        end

        // reset during m1 ACCESS while m0 is pending
        force_w = 6;
        k = 0;
        while (!(busy && owner && t == 2) && k < 40) begin
            step();
            k++;
        end
        chk("reach_m1_access", (k < 40) ? 1 : 0, 1);
        force_w = 0;
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        done_q.delete();
        k = 0;
        while (done_q.size() == 0 && k < 20) begin
            step();
            k++;
        end
        chk("post_reset_done", (done_q.size() > 0) ? 1 : 0, 1);
        if (done_q.size() > 0) chk("post_reset_first", done_q[0], 0);

        // random traffic
        force_w = -1;
        prob[0] = 30;
        prob[1] = 30;
        repeat (3000) step();
        prob[0] = 0;
        prob[1] = 0;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
